// File: rtl/seq_divider.sv
// seq_divider: multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring on magnitudes.
// Holds the issuing stage via stall and returns the result with a one-cycle done pulse.
module seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
  localparam logic [W-1:0]  ONES_W  = {W{1'b1}};
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MIN_INT = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_C  = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [W-1:0] twos_neg(input logic [W-1:0] v);
    return (~v) + ONE_W;
  endfunction

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  result_q;
  logic          is_rem_q;
  logic          neg_res_q;
  logic          done_q;

  logic          signed_op_s;
  logic          a_neg_s;
  logic          b_neg_s;
  logic          div_zero_s;
  logic          ovf_s;
  logic          special_s;
  logic [W-1:0]  a_mag_s;
  logic [W-1:0]  b_mag_s;
  logic [W-1:0]  special_res_s;

  logic [W:0]    shift_s;
  logic [W:0]    trial_s;
  logic [W-1:0]  mag_s;
  logic [W-1:0]  rem_d;
  logic [W-1:0]  quo_d;
  logic [W-1:0]  result_calc_d;

  // Operand capture: magnitudes, sign flags and the two early-exit cases.
  always_comb begin
    signed_op_s = ~op[0];
    a_neg_s     = signed_op_s & dividend[W-1];
    b_neg_s     = signed_op_s & divisor[W-1];
    a_mag_s     = a_neg_s ? twos_neg(dividend) : dividend;
    b_mag_s     = b_neg_s ? twos_neg(divisor) : divisor;
    div_zero_s  = (divisor == ZERO_W);
    ovf_s       = signed_op_s && (dividend == MIN_INT) && (divisor == ONES_W);
    special_s   = div_zero_s || ovf_s;
    if (div_zero_s) begin
      special_res_s = op[1] ? dividend : ONES_W;
    end else if (ovf_s) begin
      special_res_s = op[1] ? ZERO_W : MIN_INT;
    end else begin
      special_res_s = ZERO_W;
    end
  end

  // One restoring step; the W+1-bit trial exposes the borrow as its top bit.
  always_comb begin
    shift_s = {rem_q, quo_q[W-1]};
    trial_s = shift_s - {1'b0, dvs_q};
    if (!trial_s[W]) begin
      rem_d = trial_s[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_d = shift_s[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b0};
    end
    mag_s         = is_rem_q ? rem_d : quo_d;
    result_calc_d = neg_res_q ? twos_neg(mag_s) : mag_s;
  end

  // Control FSM and datapath registers; priority is rst, then flush, then start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      result_q  <= ZERO_W;
      count_q   <= ZERO_C;
      rem_q     <= ZERO_W;
      quo_q     <= ZERO_W;
      dvs_q     <= ZERO_W;
      is_rem_q  <= 1'b0;
      neg_res_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            is_rem_q  <= op[1];
            // Remainder follows the dividend sign; quotient negates when signs differ.
            neg_res_q <= op[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
            if (special_s) begin
              result_q <= special_res_s;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              rem_q   <= ZERO_W;
              quo_q   <= a_mag_s;
              dvs_q   <= b_mag_s;
              count_q <= ZERO_C;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + ONE_C;
            if (count_q == LAST_C) begin
              result_q <= result_calc_d;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // The stale request is still high here, so start is ignored.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs: stall covers the accept cycle and all of CALC; flush masks done.
  always_comb begin
    stall = !rst && (((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC));
    done  = done_q && !flush;
  end

  assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: randomized ops plus directed corner cases against a
// cycle-level behavioural model built from plain arithmetic and latency counts.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Cycle-level model: remaining busy cycles, pending/held result, done flag.
  int          m_busy   = 0;
  logic        m_done   = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend   = 32'd0;
  logic        armed    = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      check("stall", {31'd0, stall},
            {31'd0, !rst && ((m_busy == 0 && !m_done && start && !flush) || m_busy > 0)});
      check("done", {31'd0, done}, {31'd0, m_done && !flush});
      check("result", result, m_result);
    end
    if (rst) begin
      m_busy   = 0;
      m_done   = 1'b0;
      m_result = 32'd0;
      armed    = 1'b1;
    end else if (m_busy > 0) begin
      if (flush) begin
        m_busy = 0;
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_done   = 1'b1;
          m_result = m_pend;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start && !flush) begin
      m_pend = ref_res(op, dividend, divisor);
      if (is_special(op, dividend, divisor)) begin
        m_done   = 1'b1;
        m_result = m_pend;
      end else begin
        m_busy = 32;
      end
    end
  end

  // Issue one op; returns on the negedge of the done cycle so a following call is back-to-back.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_stalls, input int flush_at);
    int   stalls;
    logic got;
    logic aborted;
    stalls  = 0;
    got     = 1'b0;
    aborted = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    flush    = 1'b0;
    op       = o;
    dividend = a;
    divisor  = b;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (flush_at > 0 && i == flush_at) begin
        flush = 1'b1;
        start = 1'b0;
      end
      @(negedge clk);
      if (flush) begin
        aborted = 1'b1;
        break;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      if (stall) stalls++;
    end
    if (aborted) begin
      @(posedge clk);
      #1;
      flush = 1'b0;
    end else begin
      check({nm, "_timeout"}, {31'd0, got}, 32'd1);
      check({nm, "_res"}, result, exp_r);
      check({nm, "_stalls"}, stalls, exp_stalls);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'd0 - 32'($urandom_range(1, 20));
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          fa;
    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'd0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_result", result, 32'd0);

    run_op("div_100_7", 2'd0, 32'd100, 32'd7, 32'd14, 33, -1);
    idle(1);
    run_op("rem_100_7", 2'd2, 32'd100, 32'd7, 32'd2, 33, -1);
    idle(2);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, -1);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, -1);
    run_op("divu_big_2", 2'd1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, -1);
    idle(1);
    run_op("divu_5_0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1);
    run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 1, -1);
    idle(1);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, -1);
    idle(2);

    // Flush on the 10th CALC cycle, then an immediate new op.
    @(posedge clk);
    #1;
    start    = 1'b1;
    op       = 2'd0;
    dividend = 32'd1000;
    divisor  = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("flush_calc_stall", {31'd0, stall}, 32'd1);
    check("flush_calc_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", {31'd0, stall}, 32'd0);
    check("flush_keeps_result", result, 32'd0);
    run_op("div_9_3", 2'd0, 32'd9, 32'd3, 32'd3, 33, -1);
    idle(1);

    run_op("remu_17_5", 2'd3, 32'd17, 32'd5, 32'd2, 33, -1);
    run_op("divu_17_5", 2'd1, 32'd17, 32'd5, 32'd3, 33, -1);
    idle(1);

    // Synchronous reset in the middle of CALC.
    @(posedge clk);
    #1;
    start    = 1'b1;
    op       = 2'd0;
    dividend = 32'd1000;
    divisor  = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("rst_forces_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);

    // Flush in the DONE cycle suppresses the pulse.
    @(posedge clk);
    #1;
    start    = 1'b1;
    op       = 2'd1;
    dividend = 32'd5;
    divisor  = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_pulse", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("after_flush_done", {31'd0, done}, 32'd0);

    for (int n = 0; n < 150; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = rand_val();
      rb = rand_val();
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 34)) : -1;
      run_op("rand", ro, ra, rb, ref_res(ro, ra, rb), is_special(ro, ra, rb) ? 1 : 33, fa);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
